// File: rtl/div_clk_arbiter.sv
// Round-robin arbiter that lends one programmable clock divider to NREQ requesters,
// one burst of BURST divided periods per grant.
module div_clk_arbiter #(
  parameter int NREQ  = 4,
  parameter int CNTW  = 24,
  parameter int BURST = 8
) (
  input  logic                 clkI,
  input  logic                 rstI,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CNTW-1:0] cfgM,
  input  logic [NREQ*CNTW-1:0] cfgN,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 clkO,
  output logic                 tickO,
  output logic                 doneO,
  output logic [1:0]           o_dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_RUN     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  // Handshake: req is a level; a requester owns the divider from the grant edge
  // until RELEASE and must hold its req bit high for the whole burst, otherwise
  // the burst is aborted without doneO.

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     r_owner;
  logic [NREQ-1:0]   r_grant;
  logic [CNTW-1:0]   r_m;
  logic [CNTW-1:0]   r_n;
  logic [CNTW-1:0]   r_cnt;
  logic [BW-1:0]     r_burst;
  logic              r_clk;
  logic              r_tick;
  logic              r_done;

  logic [IW-1:0]     w_win;
  logic [IW-1:0]     w_hi_win;
  logic [IW-1:0]     w_any_win;
  logic              w_hi_found;
  logic              w_found;
  logic [CNTW-1:0]   w_cfg_m;
  logic [CNTW-1:0]   w_cfg_n;
  logic              w_period_end;
  logic              w_burst_end;
  logic              w_abort;

  // Winner: lowest set bit at or above the pointer, else lowest set bit overall (wrap).
  always_comb begin
    w_hi_win   = '0;
    w_any_win  = '0;
    w_hi_found = 1'b0;
    w_found    = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        w_any_win = IW'(k);
        w_found   = 1'b1;
      end
      if (req[k] && (IW'(k) >= r_ptr)) begin
        w_hi_win   = IW'(k);
        w_hi_found = 1'b1;
      end
    end
    w_win = w_hi_found ? w_hi_win : w_any_win;
  end

  assign w_cfg_m      = cfgM[r_owner*CNTW +: CNTW];
  assign w_cfg_n      = cfgN[r_owner*CNTW +: CNTW];
  assign w_period_end = (r_cnt == r_m);
  assign w_burst_end  = w_period_end && (r_burst == BW'(BURST - 1));
  assign w_abort      = !req[r_owner];

  always_ff @(posedge clkI) begin
    if (rstI) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_found) w_state_nxt = S_LOAD;
      S_LOAD:    w_state_nxt = S_RUN;
      S_RUN:     if (w_abort || w_burst_end) w_state_nxt = S_RELEASE;
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clkI) begin
    if (rstI) begin
      r_ptr   <= '0;
      r_owner <= '0;
      r_grant <= '0;
      r_m     <= CNTW'(1);
      r_n     <= '0;
      r_cnt   <= CNTW'(1);
      r_burst <= '0;
      r_clk   <= 1'b0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner <= w_win;
            r_grant <= NREQ'(1) << w_win;
          end
        end
        S_LOAD: begin
          // A zero period would never match the counter; treat it as period 1.
          r_m     <= (w_cfg_m == '0) ? CNTW'(1) : w_cfg_m;
          r_n     <= w_cfg_n;
          r_cnt   <= CNTW'(1);
          r_burst <= '0;
          r_clk   <= 1'b0;
        end
        S_RUN: begin
          r_clk <= (r_cnt >= r_n) || w_period_end;
          if (w_period_end) begin
            r_cnt   <= CNTW'(1);
            r_tick  <= 1'b1;
            r_burst <= r_burst + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_burst_end && !w_abort) r_done <= 1'b1;
        end
        S_RELEASE: begin
          r_grant <= '0;
          r_clk   <= 1'b0;
          r_ptr   <= (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign grant       = r_grant;
  assign busy        = (r_state != S_IDLE);
  assign clkO        = r_clk;
  assign tickO       = r_tick;
  assign doneO       = r_done;
  assign o_dbg_state = r_state;

endmodule
